// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and NOP bubble constants for the pipeline controller
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        HOLD       = 2'd3
    } state_e;

    // Contents a bubbled pipeline register (regD/regE/regM/regW) is loaded with
    typedef struct packed {
        logic        commit;
        logic        reg_wen;
        logic [31:0] info;
    } nop_t;

    localparam nop_t NOP = '{commit: 1'b0, reg_wen: 1'b0, info: 32'd0};

endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use compare between decode sources and the execute-stage load
module pipe_hazard_detect (
    input  logic       is_load_i,
    input  logic       reg_wen_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    output logic       hazard_o
);

    // x0 is never written, so a load targeting it cannot create a dependency
    assign hazard_o = is_load_i & reg_wen_i & (rd_i != 5'd0) &
                      ((rs1_used_i & (rs1_i == rd_i)) | (rs2_used_i & (rs2_i == rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for regD/regE/regM/regW; PIPE_CTRL_PERF_EN adds stall/flush cycle counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FLUSH_EXTRA      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         decode_i_rs1,
    input  logic [4:0]         decode_i_rs2,
    input  logic               decode_i_rs1_used,
    input  logic               decode_i_rs2_used,
    input  logic [4:0]         regE_i_rd,
    input  logic               regE_i_reg_wen,
    input  logic               regE_i_is_load,
    input  logic               execute_i_redirect,
    input  logic               execute_i_busy,
    input  logic               mem_i_busy,
    output logic               ctrl_o_pc_stall,
    output logic               ctrl_o_regD_stall,
    output logic               ctrl_o_regD_bubble,
    output logic               ctrl_o_regE_stall,
    output logic               ctrl_o_regE_bubble,
    output logic               ctrl_o_regM_stall,
    output logic               ctrl_o_regM_bubble,
    output logic               ctrl_o_regW_bubble,
    output logic [STATE_W-1:0] ctrl_o_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        ctrl_o_stall_cnt,
    output logic [31:0]        ctrl_o_flush_cnt
`endif
);

    localparam int MAX_CNT = (LOAD_USE_BUBBLES > FLUSH_EXTRA) ? LOAD_USE_BUBBLES : FLUSH_EXTRA;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int LS_INIT = (LOAD_USE_BUBBLES > 1) ? LOAD_USE_BUBBLES - 2 : 0;
    localparam int FL_INIT = (FLUSH_EXTRA > 0) ? FLUSH_EXTRA - 1 : 0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          hazard;
    logic          pc_s, d_s, d_b, e_s, e_b, m_s, m_b, w_b;

    pipe_hazard_detect u_hazard (
        .is_load_i  (regE_i_is_load),
        .reg_wen_i  (regE_i_reg_wen),
        .rd_i       (regE_i_rd),
        .rs1_i      (decode_i_rs1),
        .rs2_i      (decode_i_rs2),
        .rs1_used_i (decode_i_rs1_used),
        .rs2_used_i (decode_i_rs2_used),
        .hazard_o   (hazard)
    );

    // Next state and controls by priority: mem busy, execute busy, redirect, then per-state work
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pc_s    = 1'b0;
        d_s     = 1'b0;
        d_b     = 1'b0;
        e_s     = 1'b0;
        e_b     = 1'b0;
        m_s     = 1'b0;
        m_b     = 1'b0;
        w_b     = 1'b0;
        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else if (mem_i_busy || execute_i_busy) begin
            pc_s    = 1'b1;
            d_s     = 1'b1;
            e_s     = 1'b1;
            m_s     = mem_i_busy;
            w_b     = mem_i_busy;
            m_b     = !mem_i_busy;
            pend_d  = pend_q | execute_i_redirect;
            state_d = HOLD;
        end else if (execute_i_redirect || pend_q) begin
            d_b     = 1'b1;
            e_b     = 1'b1;
            pend_d  = 1'b0;
            cnt_d   = CW'(FL_INIT);
            state_d = (FLUSH_EXTRA > 0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                FLUSH: begin
                    d_b     = 1'b1;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? RUN : FLUSH;
                end
                LOAD_STALL: begin
                    pc_s    = 1'b1;
                    d_s     = 1'b1;
                    e_b     = 1'b1;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? RUN : LOAD_STALL;
                end
                default: begin
                    pc_s    = hazard;
                    d_s     = hazard;
                    e_b     = hazard;
                    cnt_d   = hazard ? CW'(LS_INIT) : cnt_q;
                    state_d = (hazard && LOAD_USE_BUBBLES > 1) ? LOAD_STALL : RUN;
                end
            endcase
        end
    end

    // State, counter and pending-redirect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign ctrl_o_pc_stall    = pc_s;
    assign ctrl_o_regD_stall  = d_s & ~d_b;
    assign ctrl_o_regD_bubble = d_b;
    assign ctrl_o_regE_stall  = e_s & ~e_b;
    assign ctrl_o_regE_bubble = e_b;
    assign ctrl_o_regM_stall  = m_s & ~m_b;
    assign ctrl_o_regM_bubble = m_b;
    assign ctrl_o_regW_bubble = w_b;
    assign ctrl_o_state       = state_q;

    // A register is never told to hold and load a NOP in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ctrl_o_regD_stall && ctrl_o_regD_bubble) &&
                    !(ctrl_o_regE_stall && ctrl_o_regE_bubble) &&
                    !(ctrl_o_regM_stall && ctrl_o_regM_bubble))
                else $error("pipe_ctrl: stall and bubble both set on one register");
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running cycle counters for PC stalls and regD bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, ctrl_o_pc_stall};
            flush_cnt_q <= flush_cnt_q + {31'd0, ctrl_o_regD_bubble};
        end
    end

    assign ctrl_o_stall_cnt = stall_cnt_q;
    assign ctrl_o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized check of pipe_ctrl against a cycle-count reference model
module tb_pipe_ctrl;

    localparam int LUB = 3;
    localparam int FE  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wen, ld, redir, ebusy, mbusy;
    logic       pc_s, d_s, d_b, e_s, e_b, m_s, m_b, w_b;
    logic [1:0] st;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned m_stall = 0, m_flush = 0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    int ls_left = 0;
    int fl_left = 0;
    bit pend    = 0;
    int exp_st  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_USE_BUBBLES(LUB), .FLUSH_EXTRA(FE)) dut (
        .clk                (clk),
        .rst                (rst),
        .decode_i_rs1       (rs1),
        .decode_i_rs2       (rs2),
        .decode_i_rs1_used  (u1),
        .decode_i_rs2_used  (u2),
        .regE_i_rd          (rd),
        .regE_i_reg_wen     (wen),
        .regE_i_is_load     (ld),
        .execute_i_redirect (redir),
        .execute_i_busy     (ebusy),
        .mem_i_busy         (mbusy),
        .ctrl_o_pc_stall    (pc_s),
        .ctrl_o_regD_stall  (d_s),
        .ctrl_o_regD_bubble (d_b),
        .ctrl_o_regE_stall  (e_s),
        .ctrl_o_regE_bubble (e_b),
        .ctrl_o_regM_stall  (m_s),
        .ctrl_o_regM_bubble (m_b),
        .ctrl_o_regW_bubble (w_b),
        .ctrl_o_state       (st)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .ctrl_o_stall_cnt   (stall_cnt),
        .ctrl_o_flush_cnt   (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input logic r, input logic rdr, input logic eb, input logic mb,
                        input logic l, input logic w, input logic [4:0] d,
                        input logic a1, input logic [4:0] s1, input logic a2, input logic [4:0] s2);
        logic [7:0] e;
        logic       haz;
        @(negedge clk);
        rst = r; redir = rdr; ebusy = eb; mbusy = mb;
        ld = l; wen = w; rd = d; u1 = a1; rs1 = s1; u2 = a2; rs2 = s2;
        #1;
        haz = l && w && d != 0 && ((a1 && s1 == d) || (a2 && s2 == d));
        // bit order: pc, Dstall, Dbub, Estall, Ebub, Mstall, Mbub, Wbub
        if (r)                 e = 8'b0000_0000;
        else if (mb)           e = 8'b1101_0101;
        else if (eb)           e = 8'b1101_0010;
        else if (rdr || pend)  e = 8'b0010_1000;
        else if (fl_left > 0)  e = 8'b0010_0000;
        else if (ls_left > 0)  e = 8'b1100_1000;
        else if (haz)          e = 8'b1100_1000;
        else                   e = 8'b0000_0000;
        chk("ctrl", {24'd0, pc_s, d_s, d_b, e_s, e_b, m_s, m_b, w_b}, {24'd0, e});
        chk("state", {30'd0, st}, exp_st);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        m_stall = r ? 0 : m_stall + e[7];
        m_flush = r ? 0 : m_flush + e[5];
`endif
        if (r) begin
            ls_left = 0; fl_left = 0; pend = 0; exp_st = 0;
        end else if (mb || eb) begin
            pend = pend || rdr; ls_left = 0; fl_left = 0; exp_st = 3;
        end else begin
            if (rdr || pend) begin
                pend = 0; fl_left = FE; ls_left = 0;
            end else if (fl_left > 0) fl_left--;
            else if (ls_left > 0) ls_left--;
            else if (haz) ls_left = LUB - 1;
            exp_st = (fl_left > 0) ? 2 : (ls_left > 0) ? 1 : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; redir = 0; ebusy = 0; mbusy = 0;
        ld = 0; wen = 0; rd = 0; u1 = 0; rs1 = 0; u2 = 0; rs2 = 0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use on rs2: three stall/bubble cycles, then RUN
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 5);
        idle(1);
        chk("run_after_loaduse", {30'd0, st}, 0);
        // load to x0 never stalls
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        // redirect pulse then flush tail
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // memory busy with a redirect arriving mid-stall
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // execute busy masks a hazard, which is honoured once busy drops
        step(0, 0, 1, 0, 1, 1, 7, 1, 7, 0, 0);
        step(0, 0, 1, 0, 1, 1, 7, 1, 7, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 7, 1, 7, 0, 0);
        idle(1);
        // reset in the middle of a flush
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // randomized traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 12,
                 $urandom_range(99) < 10, $urandom_range(99) < 8,
                 $urandom_range(99) < 40, $urandom_range(99) < 80, 5'($urandom_range(3)),
                 1'($urandom), 5'($urandom_range(3)), 1'($urandom), 5'($urandom_range(3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
